array_count_scheduler: RTL and testbench
========================================

// Module: array_count_scheduler
// PURPOSE
//  Shares one single-port heap read path among NReq requesters, each issuing arrayCountLess commands.
//  Per command: looks up the array size, scans the array area one element per cycle, and counts elements below the key.
//  The count is returned to the requester that issued the command.
//  Sits between the instruction engines and the heapMem/arraySizes storage; replaces the single-cycle NArea-wide compare.
// PARAMETERS
//  MemoryElementWidth  12  width of heap elements, keys, counts, array indices
//  NArea               3   elements per array area; heap address = array*NArea + i
//  NArrays             1   number of arrays; legal array index 0..NArrays-1
//  NReq                2   number of requesters
// PORTS
//  clock         in   1        single clock, all state on posedge
//  reset         in   1        synchronous, active-high
//  req_valid     in   NReq     requester r presents a command
//  req_ready     out  NReq     one-hot grant; command accepted when req_valid[r] && req_ready[r]
//  req_array     in   NReq*W   array index per requester (W = MemoryElementWidth)
//  req_key       in   NReq*W   compare key per requester, unsigned
//  rsp_valid     out  NReq     one-cycle pulse to the owning requester
//  rsp_count     out  W        count, valid only while any rsp_valid is high
//  rsp_error     out  1        array index out of range, valid with rsp_valid
//  size_array    out  W        arraySizes read index
//  size_data     in   W        arraySizes[size_array], combinational
//  heap_rd_en    out  1        heap read strobe
//  heap_rd_addr  out  W        heap read address
//  heap_rd_data  in   W        read data, valid 1 cycle after heap_rd_en
//  busy          out  1        high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE; req_ready, rsp_valid, rsp_count, rsp_error, heap_rd_en and busy are 0; RR pointer=0.
//  Reset during any state aborts the command: no rsp_valid, no further reads.
//  States: IDLE -> SIZE -> SCAN -> LAST -> DONE -> IDLE; a zero-length or error command goes SIZE -> DONE.
//  IDLE: req_ready = RR grant among asserted req_valid, starting at pointer; pointer <= grant+1 mod NReq on accept.
//   req_ready never asserts outside IDLE; an un-granted requester holds its command.
//  Accept cycle = cycle 0. Latch the owner, array and key.
//  SIZE (cycle 1): size_array=array. If array >= NArrays: error=1, count=0.
//   Otherwise k = min(size_data, NArea) and count=0.
//  SCAN (cycles 2..k+1): heap_rd_en=1, addr=array*NArea+i, i=0..k-1 back to back.
//   Each returned datum is compared on the following cycle: count += (data < key).
//  LAST (cycle k+2): final compare, no read.
//  DONE (cycle k+3; cycle 2 if k=0 or error): rsp_valid[owner]=1 for exactly one cycle; next state IDLE.
//  Minimum gap between commands is 1 IDLE cycle; back-to-back acceptance is not supported.
//  Arithmetic: unsigned compare; the count is never more than NArea, so it cannot overflow W.
//  Address multiply is done in W bits; NArrays*NArea must not exceed 2**W.
//  Simultaneous req_valid: RR order only; no requester waits more than NReq-1 grants.
// CONFIGURATION
//  ARRAY_COUNT_SCHEDULER_GREATER_EN defined:
//   adds input req_greater[NReq], latched at accept.
//   When set, the count uses (data > key) instead of (data < key); latency is unchanged.
//  Undefined: no port, less-than only.
// STRUCTURE
//  Package array_sched_pkg holds:
//   typedef enum {IDLE,SIZE,SCAN,LAST,DONE} sched_state_t;
//   localparam MemoryElementWidth default;
//   the command struct {array,key[,greater]}.
//  Sub-module array_rr_arbiter(NReq): inputs req, pointer; output one-hot grant. Purely combinational.
//  The pointer register lives in the parent.
// TESTING
//  1. Array 0 = [10,20,30], size 3, r0 key 20 -> accept cycle 0, rsp_valid[0] at cycle 6, count=1, error=0.
//  2. Size 0, key 99 -> no heap_rd_en, rsp_valid at cycle 2, count=0.
//  3. size_data=7 with NArea=3, data [1,2,3], key 100 -> exactly 3 reads, count=3.
//  4. r0 and r1 both valid at reset release ->
//     r0 granted first, r1 second; r1 re-requests with r0 -> r1 is not granted before r0.
//  5. req_array=5 with NArrays=1 -> rsp_error=1, count=0, no reads, rsp at cycle 2.
//  6. Reset asserted in SCAN cycle 3 -> no rsp_valid; IDLE the cycle after reset; busy=0; the next command is correct.

Source files
------------

// File: rtl/array_sched_pkg.sv
// Shared types and constants for the array count scheduler.
//  - MemoryElementWidth : width of heap elements, keys, counts and array indices
//  - sched_state_t      : scheduler FSM states
//  - sched_cmd_t        : command captured from the granted requester
// Optional feature macro: ARRAY_COUNT_SCHEDULER_GREATER_EN adds the 'greater'
// field to the command (count data > key instead of data < key).
package array_sched_pkg;

  localparam int MemoryElementWidth = 12;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SIZE = 3'd1,
    SCAN = 3'd2,
    LAST = 3'd3,
    DONE = 3'd4
  } sched_state_t;

  typedef struct packed {
    logic [MemoryElementWidth-1:0] array;
    logic [MemoryElementWidth-1:0] key;
`ifdef ARRAY_COUNT_SCHEDULER_GREATER_EN
    logic                          greater;
`endif
  } sched_cmd_t;

endpackage

// File: rtl/array_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
// Ports:
//  req     in  NReq   request vector
//  pointer in  PtrW   index of the highest-priority requester
//  grant   out NReq   one-hot grant (all zero when no request)
module array_rr_arbiter #(
  parameter int NReq = 2,
  parameter int PtrW = (NReq > 1) ? $clog2(NReq) : 1
) (
  input  logic [NReq-1:0] req,
  input  logic [PtrW-1:0] pointer,
  output logic [NReq-1:0] grant
);

  // First asserted request found when walking upward from the pointer, wrapping.
  always_comb begin
    logic found_s;
    int   idx_s;
    grant   = {NReq{1'b0}};
    found_s = 1'b0;
    idx_s   = 0;
    for (int i = 0; i < NReq; i++) begin
      idx_s = (int'(pointer) + i) % NReq;
      if (!found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/array_count_scheduler.sv
// Shares one heap read port among NReq requesters issuing arrayCountLess
// commands. For each accepted command the array size is looked up, the array
// area is scanned one element per cycle and elements below the key are counted;
// the count is returned to the issuing requester as a one-cycle pulse.
// Ports:
//  clock, reset                 single clock, synchronous active-high reset
//  req_valid/req_ready          per-requester handshake, one-hot grant in IDLE only
//  req_array/req_key            packed per-requester command fields
//  req_greater                  (ARRAY_COUNT_SCHEDULER_GREATER_EN only) count data > key
//  rsp_valid/rsp_count/rsp_error response pulse to the owner
//  size_array/size_data         arraySizes lookup (combinational data)
//  heap_rd_en/addr/data         heap read port, data one cycle after the strobe
//  busy                         high whenever not IDLE
// Optional feature macro: ARRAY_COUNT_SCHEDULER_GREATER_EN.
module array_count_scheduler
  import array_sched_pkg::*;
#(
  parameter int NArea   = 3,
  parameter int NArrays = 1,
  parameter int NReq    = 2
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NReq-1:0]                     req_valid,
  output logic [NReq-1:0]                     req_ready,
  input  logic [NReq*MemoryElementWidth-1:0]  req_array,
  input  logic [NReq*MemoryElementWidth-1:0]  req_key,
`ifdef ARRAY_COUNT_SCHEDULER_GREATER_EN
  input  logic [NReq-1:0]                     req_greater,
`endif
  output logic [NReq-1:0]                     rsp_valid,
  output logic [MemoryElementWidth-1:0]       rsp_count,
  output logic                                rsp_error,
  output logic [MemoryElementWidth-1:0]       size_array,
  input  logic [MemoryElementWidth-1:0]       size_data,
  output logic                                heap_rd_en,
  output logic [MemoryElementWidth-1:0]       heap_rd_addr,
  input  logic [MemoryElementWidth-1:0]       heap_rd_data,
  output logic                                busy
);

  localparam int W    = MemoryElementWidth;
  localparam int PtrW = (NReq > 1) ? $clog2(NReq) : 1;
  localparam logic [W-1:0] ZeroW  = {W{1'b0}};
  localparam logic [W-1:0] OneW   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] AreaW  = W'(NArea);

  sched_state_t     state_r;
  logic [PtrW-1:0]  pointer_r;
  logic [PtrW-1:0]  pointer_next_s;
  logic [PtrW-1:0]  gidx_s;
  logic [NReq-1:0]  grant_s;
  logic [NReq-1:0]  owner_r;
  logic [NReq-1:0]  rsp_valid_r;
  sched_cmd_t       cmd_s;
  sched_cmd_t       cmd_r;
  logic             accept_s;
  logic             array_err_s;
  logic             hit_s;
  logic [W-1:0]     ksel_s;
  logic [W-1:0]     base_s;
  logic [W-1:0]     k_r;
  logic [W-1:0]     idx_r;
  logic [W-1:0]     addr_r;
  logic [W-1:0]     count_r;
  logic             error_r;
  logic             rd_en_r;
  logic             rd_pend_r;
  logic             busy_r;

  array_rr_arbiter #(.NReq(NReq), .PtrW(PtrW)) u_arb (
    .req     (req_valid),
    .pointer (pointer_r),
    .grant   (grant_s)
  );

  // Grant is only offered in IDLE and never while reset is held.
  always_comb begin
    if ((state_r == IDLE) && !reset) begin
      req_ready = grant_s;
    end else begin
      req_ready = {NReq{1'b0}};
    end
    accept_s = |(req_ready & req_valid);
  end

  // Mux the granted requester's command and compute the pointer after it.
  always_comb begin
    gidx_s = {PtrW{1'b0}};
    cmd_s  = sched_cmd_t'({$bits(sched_cmd_t){1'b0}});
    for (int r = 0; r < NReq; r++) begin
      if (grant_s[r]) begin
        gidx_s        = PtrW'(r);
        cmd_s.array   = req_array[r*W +: W];
        cmd_s.key     = req_key[r*W +: W];
`ifdef ARRAY_COUNT_SCHEDULER_GREATER_EN
        cmd_s.greater = req_greater[r];
`endif
      end else begin
        gidx_s = gidx_s;
      end
    end
    if (int'(gidx_s) == NReq - 1) begin
      pointer_next_s = {PtrW{1'b0}};
    end else begin
      pointer_next_s = gidx_s + PtrW'(1'b1);
    end
  end

  // Size lookup, scan base address and per-element compare.
  always_comb begin
    array_err_s = (32'(cmd_r.array) >= NArrays);
    if (size_data > AreaW) begin
      ksel_s = AreaW;
    end else begin
      ksel_s = size_data;
    end
    // Multiply kept in W bits; NArrays*NArea fits by construction.
    base_s = W'(cmd_r.array * AreaW);
`ifdef ARRAY_COUNT_SCHEDULER_GREATER_EN
    if (cmd_r.greater) begin
      hit_s = (heap_rd_data > cmd_r.key);
    end else begin
      hit_s = (heap_rd_data < cmd_r.key);
    end
`else
    hit_s = (heap_rd_data < cmd_r.key);
`endif
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      pointer_r   <= {PtrW{1'b0}};
      owner_r     <= {NReq{1'b0}};
      cmd_r       <= sched_cmd_t'({$bits(sched_cmd_t){1'b0}});
      k_r         <= ZeroW;
      idx_r       <= ZeroW;
      addr_r      <= ZeroW;
      count_r     <= ZeroW;
      error_r     <= 1'b0;
      rd_en_r     <= 1'b0;
      rd_pend_r   <= 1'b0;
      rsp_valid_r <= {NReq{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      // A datum is on heap_rd_data exactly one cycle after its strobe.
      rd_pend_r <= rd_en_r;
      case (state_r)
        IDLE: begin
          rsp_valid_r <= {NReq{1'b0}};
          if (accept_s) begin
            owner_r   <= grant_s;
            cmd_r     <= cmd_s;
            pointer_r <= pointer_next_s;
            busy_r    <= 1'b1;
            state_r   <= SIZE;
          end else begin
            busy_r    <= 1'b0;
          end
        end
        SIZE: begin
          count_r <= ZeroW;
          idx_r   <= ZeroW;
          addr_r  <= base_s;
          if (array_err_s) begin
            error_r     <= 1'b1;
            k_r         <= ZeroW;
            rsp_valid_r <= owner_r;
            state_r     <= DONE;
          end else if (ksel_s == ZeroW) begin
            error_r     <= 1'b0;
            k_r         <= ZeroW;
            rsp_valid_r <= owner_r;
            state_r     <= DONE;
          end else begin
            error_r <= 1'b0;
            k_r     <= ksel_s;
            rd_en_r <= 1'b1;
            state_r <= SCAN;
          end
        end
        SCAN: begin
          if (rd_pend_r && hit_s) begin
            count_r <= count_r + OneW;
          end else begin
            count_r <= count_r;
          end
          addr_r <= addr_r + OneW;
          idx_r  <= idx_r + OneW;
          if (idx_r == (k_r - OneW)) begin
            rd_en_r <= 1'b0;
            state_r <= LAST;
          end else begin
            rd_en_r <= 1'b1;
          end
        end
        LAST: begin
          // Compare of the datum returned for the final read.
          if (hit_s) begin
            count_r <= count_r + OneW;
          end else begin
            count_r <= count_r;
          end
          rsp_valid_r <= owner_r;
          state_r     <= DONE;
        end
        DONE: begin
          rsp_valid_r <= {NReq{1'b0}};
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          rd_en_r     <= 1'b0;
          rsp_valid_r <= {NReq{1'b0}};
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign size_array   = cmd_r.array;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_count    = count_r;
  assign rsp_error    = error_r;
  assign heap_rd_en   = rd_en_r;
  assign heap_rd_addr = addr_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_array_count_scheduler.sv
// Self-checking bench for array_count_scheduler (NArea=3, NArrays=2, NReq=2).
module tb_array_count_scheduler;

  localparam int W     = 12;
  localparam int NAREA = 3;
  localparam int NARR  = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [11:0]   t_arr [2];
  logic [11:0]   t_key [2];
  logic [1:0]    t_gt;
  logic [1:0]    rsp_valid;
  logic [11:0]   rsp_count;
  logic          rsp_error;
  logic [11:0]   size_array;
  logic [11:0]   size_data;
  logic          heap_rd_en;
  logic [11:0]   heap_rd_addr;
  logic [11:0]   heap_rd_data;
  logic          busy;

  logic [11:0]   heap  [NARR*NAREA];
  logic [11:0]   sizes [NARR];

  int tests = 0;
  int fails = 0;
  int ptr   = 0;

  always #5 clock = ~clock;

  array_count_scheduler #(.NArea(NAREA), .NArrays(NARR), .NReq(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_array    ({t_arr[1], t_arr[0]}),
    .req_key      ({t_key[1], t_key[0]}),
`ifdef ARRAY_COUNT_SCHEDULER_GREATER_EN
    .req_greater  (t_gt),
`endif
    .rsp_valid    (rsp_valid),
    .rsp_count    (rsp_count),
    .rsp_error    (rsp_error),
    .size_array   (size_array),
    .size_data    (size_data),
    .heap_rd_en   (heap_rd_en),
    .heap_rd_addr (heap_rd_addr),
    .heap_rd_data (heap_rd_data),
    .busy         (busy)
  );

  // arraySizes: combinational; out-of-range index returns a nonzero size.
  assign size_data = (size_array < 12'(NARR)) ? sizes[size_array[0]] : 12'd7;

  // Heap: single-port memory, one cycle read latency.
  always @(posedge clock) begin
    if (heap_rd_en && (heap_rd_addr < 12'(NARR*NAREA))) heap_rd_data <= heap[heap_rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Expected outcome of one command straight from the command rules.
  task automatic model(input int arr, input int key, input int gt,
                       output int cnt, output int err, output int lat, output int reads);
    int k;
    err = (arr >= NARR) ? 1 : 0;
    k   = 0;
    if (!err) k = (int'(sizes[arr]) < NAREA) ? int'(sizes[arr]) : NAREA;
    cnt = 0;
    for (int i = 0; i < k; i++) begin
      int v;
      v = int'(heap[arr*NAREA + i]);
      if (gt != 0) cnt += (v > key) ? 1 : 0;
      else         cnt += (v < key) ? 1 : 0;
    end
    lat   = (k == 0) ? 2 : k + 3;
    reads = k;
  endtask

  function automatic logic [1:0] rr_exp(input int p, input logic [1:0] v);
    for (int i = 0; i < 2; i++) begin
      int r;
      r = (p + i) % 2;
      if (v[r]) return 2'(1 << r);
    end
    return 2'b00;
  endfunction

  // Wait (bounded) for IDLE with a grant offered, compare the grant.
  task automatic expect_grant(input logic [1:0] exp, output int who);
    int n;
    #1;
    n = 0;
    while (!((busy === 1'b0) && (req_ready !== 2'b00)) && n < 50) begin
      tick();
      n++;
    end
    check("grant", 32'(req_ready), 32'(exp));
    who = exp[1] ? 1 : 0;
    ptr = (who + 1) % 2;
  endtask

  // Follow an accepted command to its response; check reads, latency, result.
  task automatic complete_cmd(input int who);
    int cnt, err, lat, reads, seen, got;
    model(int'(t_arr[who]), int'(t_key[who]), int'(t_gt[who]), cnt, err, lat, reads);
    seen = 0;
    got  = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 1) begin
        req_valid[who] = 1'b0;
        check("busy_in_cmd", 32'(busy), 32'd1);
      end
      if (heap_rd_en === 1'b1) begin
        check("rd_addr", 32'(heap_rd_addr), 32'(int'(t_arr[who]) * NAREA + seen));
        seen++;
      end
      if (rsp_valid !== 2'b00) begin
        check("rsp_latency", 32'(n), 32'(lat));
        check("rsp_owner", 32'(rsp_valid), 32'(1 << who));
        check("rsp_count", 32'(rsp_count), 32'(cnt));
        check("rsp_error", 32'(rsp_error), 32'(err));
        got = 1;
        break;
      end
    end
    check("rsp_seen", 32'(got), 32'd1);
    check("reads", 32'(seen), 32'(reads));
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_rsp", 32'(rsp_valid), 32'd0);
  endtask

  task automatic run_cmd(input int r, input int arr, input int key);
    int who;
    t_arr[r] = 12'(arr);
    t_key[r] = 12'(key);
    req_valid[r] = 1'b1;
    expect_grant(2'(1 << r), who);
    complete_cmd(who);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    ptr = 0;
  endtask

  initial begin
    int who, stray;
    reset = 1'b1;
    req_valid = 2'b00;
    t_gt = 2'b00;
    for (int i = 0; i < 2; i++) begin t_arr[i] = 12'd0; t_key[i] = 12'd0; end
    for (int i = 0; i < NARR*NAREA; i++) heap[i] = 12'd0;
    for (int i = 0; i < NARR; i++) sizes[i] = 12'd0;
    tick(); tick(); tick();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_count", 32'(rsp_count), 32'd0);
    check("rst_error", 32'(rsp_error), 32'd0);
    check("rst_rd_en", 32'(heap_rd_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    // Array 0 = [10,20,30], size 3, key 20: one element below.
    heap[0] = 12'd10; heap[1] = 12'd20; heap[2] = 12'd30; sizes[0] = 12'd3;
    run_cmd(0, 0, 20);
    // Zero-length array.
    sizes[0] = 12'd0;
    run_cmd(0, 0, 99);
    // Size larger than the area is clamped to NArea.
    heap[0] = 12'd1; heap[1] = 12'd2; heap[2] = 12'd3; sizes[0] = 12'd7;
    run_cmd(1, 0, 100);
    // Out-of-range array index.
    run_cmd(0, 5, 50);
    // Second array exercises the base address multiply.
    heap[3] = 12'd4; heap[4] = 12'd40; heap[5] = 12'd0; sizes[1] = 12'd3;
    run_cmd(1, 1, 5);

    // Both requesters valid at reset release: r0 then r1, then again r0 then r1.
    t_arr[0] = 12'd0; t_key[0] = 12'd3;
    t_arr[1] = 12'd1; t_key[1] = 12'd41;
    reset = 1'b1;
    req_valid = 2'b11;
    tick(); tick();
    check("rst_ready_held", 32'(req_ready), 32'd0);
    reset = 1'b0;
    ptr = 0;
    expect_grant(2'b01, who); complete_cmd(who);
    expect_grant(2'b10, who); complete_cmd(who);
    req_valid = 2'b11;
    expect_grant(2'b01, who); complete_cmd(who);
    expect_grant(2'b10, who); complete_cmd(who);

    // Reset in the middle of a scan aborts the command.
    heap[0] = 12'd1; heap[1] = 12'd2; heap[2] = 12'd3; sizes[0] = 12'd3;
    t_arr[0] = 12'd0; t_key[0] = 12'd9;
    req_valid[0] = 1'b1;
    expect_grant(2'b01, who);
    tick(); req_valid[0] = 1'b0;
    tick();
    tick();
    check("scan_rd_en", 32'(heap_rd_en), 32'd1);
    reset = 1'b1;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rd_en", 32'(heap_rd_en), 32'd0);
    check("abort_rsp", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    ptr = 0;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid !== 2'b00 || heap_rd_en !== 1'b0) stray++;
    end
    check("abort_quiet", 32'(stray), 32'd0);
    run_cmd(0, 0, 3);

    // Randomized commands, one or both requesters at a time.
    for (int it = 0; it < 30; it++) begin
      logic [1:0] mask;
      for (int i = 0; i < NARR*NAREA; i++) heap[i] = 12'($urandom_range(0, 40));
      for (int i = 0; i < NARR; i++) sizes[i] = 12'($urandom_range(0, 5));
      repeat ($urandom_range(0, 2)) tick();
      mask = 2'($urandom_range(1, 3));
      for (int r = 0; r < 2; r++) begin
        if (mask[r]) begin
          t_arr[r] = 12'($urandom_range(0, 2));
          t_key[r] = 12'($urandom_range(0, 40));
`ifdef ARRAY_COUNT_SCHEDULER_GREATER_EN
          t_gt[r]  = 1'($urandom_range(0, 1));
`endif
          req_valid[r] = 1'b1;
        end
      end
      while (req_valid !== 2'b00) begin
        expect_grant(rr_exp(ptr, req_valid), who);
        complete_cmd(who);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
